// File: rtl/keccak_arbiter.sv
// Round-robin arbiter that shares one keccak core between N job streams.
// Grant takes one IDLE cycle, then words pass through combinationally; each side's ready goes straight back to the other side.
module keccak_arbiter #(
  parameter int N = 4,
  parameter int W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_last,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic [N-1:0]         rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic                 rsp_last,
  input  logic [N-1:0]         rsp_ready,
  output logic                 core_valid_i,
  output logic [W-1:0]         core_data_i,
  input  logic                 core_ready_i,
  input  logic                 core_valid_o,
  input  logic [W-1:0]         core_data_o,
  output logic                 core_ready_o,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int GW = $clog2(N);
  localparam int LW = $clog2(W);

  typedef enum logic [1:0] {IDLE, HDR, MSG, DRAIN} state_t;

  state_t          state, state_nx;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick;
  logic            pick_found;
  logic [32:0]     out_cnt;
  logic [32:0]     size_sum;
  logic [32:0]     hdr_words;
  logic [W-1:0]    req_word [N];
  logic [W-1:0]    cur_word;
  logic            cur_valid;
  logic            cur_last;
  logic            cur_rsp_rdy;
  logic            feeding;
  logic            draining;
  logic            in_xfer;
  logic            out_xfer;

  function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return GW'(s);
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_split
    assign req_word[i] = req_data[i*W +: W];
  end

  assign cur_word    = req_word[grant_id];
  assign cur_valid   = req_valid[grant_id];
  assign cur_last    = req_last[grant_id];
  assign cur_rsp_rdy = rsp_ready[grant_id];

  // Size is widened to 33 bits so the round-up cannot wrap for sizes near 2^32.
  assign size_sum  = {1'b0, cur_word[31:0]} + 33'(W - 1);
  assign hdr_words = size_sum >> LW;

  assign feeding  = (state == HDR) || (state == MSG);
  assign draining = (state == DRAIN) && (out_cnt != '0);
  assign in_xfer  = feeding && cur_valid && core_ready_i;
  assign out_xfer = draining && core_valid_o && cur_rsp_rdy;

  always_comb begin
    pick       = rr_ptr;
    pick_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && req_valid[wrap_add(rr_ptr, k)]) begin
        pick       = wrap_add(rr_ptr, k);
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid) state_nx = HDR;
      HDR:     if (in_xfer) state_nx = cur_last ? DRAIN : MSG;
      MSG:     if (in_xfer && cur_last) state_nx = DRAIN;
      DRAIN:   if ((out_cnt == '0) || (out_xfer && (out_cnt == 33'd1))) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      out_cnt  <= '0;
    end else begin
      if ((state == IDLE) && (|req_valid)) grant_id <= pick;
      if ((state == HDR) && in_xfer)       out_cnt  <= hdr_words;
      else if (out_xfer)                   out_cnt  <= out_cnt - 33'd1;
      if ((state == DRAIN) && (state_nx == IDLE)) rr_ptr <= wrap_add(grant_id, 1);
    end
  end

  // Core handshakes are active-low; idle values keep the core quiet.
  always_comb begin
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_last     = 1'b0;
    core_valid_i = 1'b1;
    core_ready_o = 1'b1;
    core_data_i  = cur_word;
    rsp_data     = core_data_o;
    busy         = (state != IDLE);
    if (feeding) begin
      req_ready[grant_id] = core_ready_i;
      core_valid_i        = !cur_valid;
    end
    if (draining) begin
      rsp_valid[grant_id] = core_valid_o;
      rsp_last            = (out_cnt == 33'd1);
      core_ready_o        = !cur_rsp_rdy;
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed bench for keccak_arbiter with a job-level scoreboard model and a small core model.
module tb_keccak_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   rsp_data, core_data_i, core_data_o;
  logic           rsp_last, core_valid_i, core_ready_i, core_valid_o, core_ready_o, busy;
  logic [1:0]     grant_id;

  keccak_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .core_valid_i(core_valid_i), .core_data_i(core_data_i), .core_ready_i(core_ready_i),
    .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_o(core_ready_o),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus / expectation queues: requester words carry {last, data}.
  logic [W:0]   drv_q [N][$];
  logic [W:0]   exp_in [N][$];
  logic [W-1:0] dig_q [$];
  logic [W-1:0] exp_dig [$];
  bit           stall_en;

  int n_chk, n_fail;

  // Job-level model state.
  bit     m_busy, m_in_done, m_first;
  int     m_owner, m_rr;
  longint m_words;
  int     g_log [$];
  int     rsp_cnt [N];
  int     last_cnt, core_words;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint words_for(input longint unsigned size);
    return longint'((size + W - 1) / W);
  endfunction

  task automatic push_job(input int i, input logic [31:0] size, input int nmsg, input int tag);
    logic [W:0] w;
    w = {(nmsg == 0), 32'(tag), size};
    drv_q[i].push_back(w);
    exp_in[i].push_back(w);
    for (int k = 0; k < nmsg; k++) begin
      w = {(k == nmsg - 1), 64'hA000_0000_0000_0000 | (64'(tag) << 16) | 64'(k)};
      drv_q[i].push_back(w);
      exp_in[i].push_back(w);
    end
  endtask

  task automatic push_dig(input int tag, input int n);
    logic [W-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = 64'hD000_0000_0000_0000 | (64'(tag) << 16) | 64'(k);
      dig_q.push_back(d);
      exp_dig.push_back(d);
    end
  endtask

  // Requester and core models: sample handshakes mid-cycle, advance just after the edge.
  initial begin : drive
    logic [N-1:0] fire;
    logic         cfire;
    logic [W:0]   tmp;
    logic [W-1:0] tmpd;
    int           cyc;
    cyc          = 0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    core_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      fire  = req_valid & req_ready;
      cfire = core_valid_o & ~core_ready_o;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (fire[i] && drv_q[i].size() > 0) tmp = drv_q[i].pop_front();
        if (drv_q[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_last[i]           = drv_q[i][0][W];
          req_data[i*W +: W]    = drv_q[i][0][W-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      if (cfire && dig_q.size() > 0) tmpd = dig_q.pop_front();
      core_valid_o = (dig_q.size() > 0);
      core_data_o  = (dig_q.size() > 0) ? dig_q[0] : '0;
      core_ready_i = stall_en ? ((cyc % 3) != 0) : 1'b1;
    end
  end

  // Compare process: one check pass per cycle against the job-level model.
  initial begin : compare
    logic [W:0]   w;
    logic [W-1:0] d;
    logic [N-1:0] oh;
    int           o, p;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_core_valid_i", core_valid_i, 1);
        chk("rst_core_ready_o", core_ready_o, 1);
        m_busy = 0; m_in_done = 0; m_first = 0; m_rr = 0; m_owner = 0; m_words = 0;
        continue;
      end
      o  = m_owner;
      oh = m_busy ? (N'(1) << o) : '0;
      chk("busy", busy, m_busy);
      chk("req_ready_iso", req_ready & ~oh, 0);
      chk("rsp_valid_iso", rsp_valid & ~oh, 0);
      if (!m_busy) begin
        chk("idle_core_valid_i", core_valid_i, 1);
        chk("idle_core_ready_o", core_ready_o, 1);
        chk("idle_rsp_last", rsp_last, 0);
        p = -1;
        for (int k = 0; k < N; k++)
          if (p < 0 && req_valid[(m_rr + k) % N]) p = (m_rr + k) % N;
        if (p >= 0) begin
          m_busy = 1; m_owner = p; m_in_done = 0; m_first = 1;
          g_log.push_back(p);
        end
      end else begin
        chk("grant_id", grant_id, o);
        if (!m_in_done) begin
          chk("core_valid_i", core_valid_i, !req_valid[o]);
          chk("req_ready_g", req_ready[o], core_ready_i);
          chk("in_rsp_valid", rsp_valid[o], 0);
          chk("in_core_ready_o", core_ready_o, 1);
          if (req_valid[o] && core_ready_i) begin
            core_words++;
            if (exp_in[o].size() == 0) begin
              chk("core_word_unexpected", 1, 0);
            end else begin
              w = exp_in[o].pop_front();
              chk("core_data_i", core_data_i, w[W-1:0]);
              if (m_first) begin
                m_words = words_for(longint'(w[31:0]));
                m_first = 0;
              end
              if (w[W]) m_in_done = 1;
            end
          end
        end else begin
          chk("drain_core_valid_i", core_valid_i, 1);
          if (m_words == 0) begin
            chk("zero_rsp_valid", rsp_valid[o], 0);
            chk("zero_core_ready_o", core_ready_o, 1);
            m_busy = 0;
            m_rr   = (o + 1) % N;
          end else begin
            chk("rsp_valid", rsp_valid[o], core_valid_o);
            chk("rsp_last", rsp_last, m_words == 1);
            chk("core_ready_o", core_ready_o, !rsp_ready[o]);
            if (core_valid_o && rsp_ready[o]) begin
              rsp_cnt[o]++;
              if (rsp_last) last_cnt++;
              if (exp_dig.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
              end else begin
                d = exp_dig.pop_front();
                chk("rsp_data", rsp_data, d);
              end
              m_words--;
              if (m_words == 0) begin
                m_busy = 0;
                m_rr   = (o + 1) % N;
              end
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_grant_id", grant_id, 0);
    chk("async_req_ready", req_ready, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_core_valid_i", core_valid_i, 1);
    chk("async_core_ready_o", core_ready_o, 1);
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      exp_in[i].delete();
    end
    dig_q.delete();
    exp_dig.delete();
    rsp_ready = '1;
    stall_en  = 0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  function automatic bit all_drained();
    bit e;
    e = (exp_dig.size() == 0);
    for (int i = 0; i < N; i++) e = e && (drv_q[i].size() == 0) && (exp_in[i].size() == 0);
    return e;
  endfunction

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(posedge clk); #1;
    while ((busy || m_busy || !all_drained()) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for idle, busy=%0b", name, busy);
      do_reset();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_until(input string name, input int which, input int target);
    int k;
    k = 0;
    while (((which < N) ? rsp_cnt[which] : core_words) < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout, count below %0d", name, target);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b, r, l, c;
    n_chk = 0; n_fail = 0; last_cnt = 0; core_words = 0;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    rst       = 1'b0;
    rsp_ready = '1;
    stall_en  = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;

    // Hand-computed word counts pin the model arithmetic.
    chk("words_size0", words_for(0), 0);
    chk("words_size1", words_for(1), 1);
    chk("words_size256", words_for(256), 4);
    chk("words_size65", words_for(65), 2);
    chk("words_sizemax", words_for(64'h0000_0000_FFFF_FFFF), 64'd67108864);

    // Single job: header + 2 message words, 4 digest words.
    r = rsp_cnt[0]; l = last_cnt; c = core_words; b = g_log.size();
    push_job(0, 32'd256, 2, 1);
    push_dig(1, 4);
    wait_idle("single_job");
    chk("single_core_words", core_words - c, 3);
    chk("single_rsp_words", rsp_cnt[0] - r, 4);
    chk("single_last_count", last_cnt - l, 1);
    chk("single_grant", g_log[b], 0);

    // Round-robin: 1 and 3 together from rr=1, then 2 and 0 after a job on 3.
    b = g_log.size();
    push_job(1, 32'd128, 1, 2);
    push_job(3, 32'd64, 0, 3);
    push_dig(2, 2);
    push_dig(3, 1);
    wait_idle("rr_1_3");
    chk("rr_count_a", g_log.size() - b, 2);
    chk("rr_first_a", g_log[b], 1);
    chk("rr_second_a", g_log[b+1], 3);
    b = g_log.size();
    push_job(2, 32'd64, 0, 4);
    push_job(0, 32'd64, 0, 5);
    push_dig(5, 1);
    push_dig(4, 1);
    wait_idle("rr_wrap");
    chk("rr_count_b", g_log.size() - b, 2);
    chk("rr_wrap_first", g_log[b], 0);
    chk("rr_wrap_second", g_log[b+1], 2);

    // Backpressure: hold rsp_ready low for 5 cycles mid-drain.
    r = rsp_cnt[1];
    push_job(1, 32'd512, 1, 6);
    push_dig(6, 8);
    wait_until("bp_wait", 1, r + 3);
    rsp_ready[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_core_ready_o", core_ready_o, 1);
      chk("bp_rsp_valid", rsp_valid[1], 1);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    wait_idle("backpressure");
    chk("bp_rsp_words", rsp_cnt[1] - r, 8);

    // Zero-size job with last on the header; rr must advance past requester 1.
    r = rsp_cnt[1]; b = g_log.size();
    push_job(1, 32'd0, 0, 7);
    wait_idle("zero_size");
    chk("zero_rsp_words", rsp_cnt[1] - r, 0);
    push_job(1, 32'd64, 0, 8);
    push_job(2, 32'd64, 0, 9);
    push_dig(9, 1);
    push_dig(8, 1);
    wait_idle("zero_rr");
    chk("zero_rr_count", g_log.size() - b, 3);
    chk("zero_rr_next", g_log[b+1], 2);
    chk("zero_rr_after", g_log[b+2], 1);

    // Odd size with the core stalling its input.
    r = rsp_cnt[3]; l = last_cnt;
    stall_en = 1;
    push_job(3, 32'd65, 3, 10);
    push_dig(10, 2);
    wait_idle("odd_size");
    stall_en = 0;
    chk("odd_rsp_words", rsp_cnt[3] - r, 2);
    chk("odd_last_count", last_cnt - l, 1);

    // Maximum size: count must not overflow to zero; reset mid-drain.
    r = rsp_cnt[0];
    push_job(0, 32'hFFFF_FFFF, 1, 11);
    push_dig(11, 3);
    wait_until("max_wait", 0, r + 3);
    repeat (2) @(negedge clk);
    chk("max_busy", busy, 1);
    chk("max_rsp_words", rsp_cnt[0] - r, 3);
    chk("max_words_left", m_words, 64'd67108861);
    do_reset();

    // Reset during MSG, then a fresh job from requester 2.
    c = core_words;
    push_job(3, 32'd256, 6, 12);
    push_dig(12, 4);
    wait_until("msg_wait", N, c + 3);
    chk("msg_busy", busy, 1);
    do_reset();
    r = rsp_cnt[2]; b = g_log.size();
    push_job(2, 32'd128, 2, 13);
    push_dig(13, 2);
    wait_idle("post_reset");
    chk("post_rst_rsp_words", rsp_cnt[2] - r, 2);
    chk("post_rst_grant", g_log[b], 2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_arbiter.md
# keccak_arbiter

Round-robin arbiter that shares one `keccak` core between `N` independent requesters. Requesters send complete jobs: a header word followed by message words. The arbiter grants one requester at a time and forwards that job's input stream into the core. It counts the digest words coming back from the core and routes them to the same requester, then releases the core for the next job.

## Interface
Parameters:
- `N`, default 4: number of requesters, 2..8.
- `W`, default 64: data word width. Must equal the core's `w` and be a power of two.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  N  per-requester input word valid, active-high.
- `req_last`  in  N  marks the final message word of a job.
- `req_data`  in  N*W  input words; requester i occupies bits [i*W +: W].
- `req_ready`  out  N  input word accepted, active-high.
- `rsp_valid`  out  N  digest word valid; only the granted bit can be set.
- `rsp_data`  out  W  digest word, shared by all requesters.
- `rsp_last`  out  1  final digest word of the job.
- `rsp_ready`  in  N  per-requester digest acceptance.
- `core_valid_i`  out  1  to the core's `valid_i`; active-low.
- `core_data_i`  out  W  to the core's `data_i`.
- `core_ready_i`  in  1  from the core's `ready_i`; active-high.
- `core_valid_o`  in  1  from the core's `valid_o`; active-high.
- `core_data_o`  in  W  from the core's `data_o`.
- `core_ready_o`  out  1  to the core's `ready_o`; active-low.
- `busy`  out  1  high whenever the arbiter is not in IDLE.
- `grant_id`  out  $clog2(N)  index of the current owner; holds its last value when idle.

## Operation
- Header word: the first word of every job.
  - Forwarded to the core unchanged.
  - The arbiter snoops only `hdr[31:0]`, the output size in bits.
  - Digest word count: `out_words = (size + W-1) >> log2(W)`, computed at 33 bits.
  - The count is stored in a 33-bit down-counter `out_cnt`.
- States are IDLE, HDR, MSG, DRAIN.
- IDLE:
  - When any `req_valid` is set, the arbiter picks the first requesting index at or after `rr_ptr`, wrapping modulo N.
  - It registers that index into `grant_id`, sets `busy`, and moves to HDR.
  - No word is accepted in the IDLE cycle.
- HDR:
  - `core_data_i = req_data[g]`.
  - `core_valid_i = !req_valid[g]`.
  - `req_ready[g] = core_ready_i`.
  - On transfer (`req_valid[g] && core_ready_i`): load `out_cnt`. If `req_last[g]` is also set, go to DRAIN; otherwise go to MSG.
- MSG:
  - Same forwarding as HDR.
  - A transfer with `req_last[g]` set moves to DRAIN.
- DRAIN:
  - `rsp_valid[g] = core_valid_o`.
  - `rsp_data = core_data_o`.
  - `core_ready_o = !rsp_ready[g]`.
  - `rsp_last = (out_cnt == 1)`.
  - Each output transfer decrements `out_cnt`.
  - The transfer with `out_cnt == 1` returns to IDLE and sets `rr_ptr = g+1 mod N`.
  - If `out_cnt == 0` on entry, DRAIN lasts one cycle with no transfer, then returns to IDLE and advances `rr_ptr`.
- Isolation:
  - Non-granted requesters always see `req_ready = 0` and `rsp_valid = 0`.
  - Outside HDR/MSG: `core_valid_i = 1` (inactive).
  - Outside DRAIN: `core_ready_o = 1` (inactive).
- `core_valid_o` asserted outside DRAIN is ignored; the core holds the word.
- Requests arriving while the arbiter is busy wait; a requester may drop `req_valid` while waiting.
- Reset mid-job: all state clears immediately. The partially fed core must be reset by the same `rst` (system integration requirement).

## Timing
- Reset values:
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_last = 0`.
  - `core_valid_i = 1`, `core_ready_o = 1`.
  - `busy = 0`, `grant_id = 0`, `rr_ptr = 0`, `out_cnt = 0`, state IDLE.
- Grant latency: one cycle from `req_valid` seen in IDLE to the first possible header transfer.
- Forwarding is purely combinational (mux only). No added latency; throughput is one word per cycle when both sides are ready.
- Between jobs: one IDLE cycle minimum after the last digest word, so a new grant can issue no earlier than the cycle after returning to IDLE.
- Arbitration is decided only in IDLE. Priority never changes mid-job.
- Word count arithmetic:
  - `size = 0` gives 0 words.
  - `size = 1` gives 1 word.
  - `size = 0xFFFFFFFF` gives 2^26 words at W=64, with no overflow.

## Test plan
- Single job, W=64: requester 0 sends header `size = 256` plus 2 message words with last on the second. Required: core receives 3 words in order; requester 0 receives 4 digest words, `rsp_last` only on the 4th; `busy` falls the next cycle.
- Round-robin: requesters 1 and 3 request simultaneously with `rr_ptr = 0`. Required: grant order 1 then 3; after a job on 3, `rr_ptr` wraps to 0.
- Backpressure: hold `rsp_ready[g] = 0` for 5 cycles mid-drain. Required: `core_ready_o` stays 1 for those cycles, `out_cnt` is held, no word is lost or duplicated.
- Zero output: header `size = 0` with last set on the header. Required: HDR → DRAIN → IDLE, no `rsp_valid`, `rr_ptr` advances.
- Odd size: `size = 65`. Required: exactly 2 digest words.
- Reset: drop `rst` during MSG. Required: all outputs return to reset values asynchronously; after release, a fresh job from requester 2 completes normally.
